bcd_field_editor: RTL

BCD_FIELD_EDITOR -- requirements
Module: bcd_field_editor

---
 rtl/bcd_field_editor.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/bcd_field_editor.sv
// Button-driven editor for a row of packed BCD fields (field 0 in the MSB byte).
// Optional auto-repeat on held up/down buttons: define BCD_EDITOR_AUTOREPEAT_EN.
module bcd_field_editor #(
   parameter int                    N_FIELDS   = 6,
   parameter logic [8*N_FIELDS-1:0] FIELD_MAX  = 48'h31_12_99_23_59_59,
   parameter logic [8*N_FIELDS-1:0] FIELD_MIN  = 48'h01_01_00_00_00_00,
   parameter int                    REPEAT_DLY = 16,
   parameter int                    REPEAT_PER = 4,
   localparam int                   SEL_W      = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    btn_p,
   input  logic                    btn_r,
   input  logic                    btn_l,
   input  logic                    btn_u,
   input  logic                    btn_d,
   input  logic [8*N_FIELDS-1:0]   load_data,
   output logic [8*N_FIELDS-1:0]   field_data,
   output logic [SEL_W-1:0]        sel,
   output logic                    editing,
   output logic                    commit,
   output logic [1:0]              state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_EDIT   = 2'd2,
      ST_COMMIT = 2'd3
   } state_t;

   if (N_FIELDS < 2 || N_FIELDS > 8 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_cfg_check
      $error("bcd_field_editor: unsupported parameter combination");
   end

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] mx,
                                          input logic [7:0] mn);
      if (v >= mx)              return mn;
      else if (v[3:0] == 4'h9)  return v + 8'h07;
      else                      return v + 8'h01;
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] mx,
                                          input logic [7:0] mn);
      if (v <= mn)              return mx;
      else if (v[3:0] == 4'h0)  return v - 8'h07;
      else                      return v - 8'h01;
   endfunction

   state_t                  state_q;
   logic [SEL_W-1:0]        sel_q;
   logic                    editing_q;
   logic                    commit_q;
   logic [8*N_FIELDS-1:0]   field_q;
   logic [8*N_FIELDS-1:0]   field_d;
   logic [4:0]              btn_prev_q;
   logic                    armed_q;

   logic [4:0]              btn_now;
   logic [4:0]              btn_edge;
   logic                    in_edit;
   logic                    any_edge;
   logic                    act_p, act_r, act_l, act_u, act_d;
   logic                    rpt_step_up, rpt_step_dn;
   logic                    step_up, step_dn;

   // armed_q masks the first sample after reset so a button already held is not an edge
   assign btn_now  = {btn_p, btn_r, btn_l, btn_u, btn_d};
   assign btn_edge = btn_now & ~btn_prev_q & {5{armed_q}};
   assign in_edit  = (state_q == ST_EDIT);
   assign any_edge = |btn_edge;

   assign act_p = in_edit & btn_edge[4];
   assign act_r = in_edit & ~btn_edge[4] & btn_edge[3];
   assign act_l = in_edit & ~(|btn_edge[4:3]) & btn_edge[2];
   assign act_u = in_edit & ~(|btn_edge[4:2]) & btn_edge[1];
   assign act_d = in_edit & ~(|btn_edge[4:1]) & btn_edge[0];

   assign step_up = act_u | rpt_step_up;
   assign step_dn = act_d | rpt_step_dn;

`ifdef BCD_EDITOR_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int CNT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

   logic              rpt_act_q;
   logic              rpt_up_q;
   logic [CNT_W-1:0]  rpt_cnt_q;
   logic              rpt_held;
   logic              rpt_fire;

   assign rpt_held    = rpt_up_q ? btn_u : btn_d;
   assign rpt_fire    = in_edit & rpt_act_q & ~any_edge & rpt_held & (rpt_cnt_q == '0);
   assign rpt_step_up = rpt_fire & rpt_up_q;
   assign rpt_step_dn = rpt_fire & ~rpt_up_q;

   // Counter reloads with DLY-1 on the edge step, then PER-1 after every repeat step
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rpt_act_q <= 1'b0;
         rpt_up_q  <= 1'b0;
         rpt_cnt_q <= '0;
      end else if (!in_edit) begin
         rpt_act_q <= 1'b0;
      end else if (any_edge) begin
         rpt_act_q <= act_u | act_d;
         rpt_up_q  <= act_u;
         rpt_cnt_q <= CNT_W'(REPEAT_DLY - 1);
      end else if (rpt_act_q && !rpt_held) begin
         rpt_act_q <= 1'b0;
      end else if (rpt_act_q) begin
         if (rpt_cnt_q == '0) rpt_cnt_q <= CNT_W'(REPEAT_PER - 1);
         else                 rpt_cnt_q <= rpt_cnt_q - 1'b1;
      end
   end
`else
   assign rpt_step_up = 1'b0;
   assign rpt_step_dn = 1'b0;
`endif

   for (genvar gi = 0; gi < N_FIELDS; gi++) begin : g_field
      localparam int         OFS   = 8 * (N_FIELDS - 1 - gi);
      localparam logic [7:0] F_MAX = FIELD_MAX[OFS +: 8];
      localparam logic [7:0] F_MIN = FIELD_MIN[OFS +: 8];

      logic [7:0] cur;
      logic [7:0] inc_v;
      logic [7:0] dec_v;
      logic       hit;

      assign cur   = field_q[OFS +: 8];
      assign hit   = (sel_q == SEL_W'(gi));
      assign inc_v = bcd_inc(cur, F_MAX, F_MIN);
      assign dec_v = bcd_dec(cur, F_MAX, F_MIN);

      assign field_d[OFS +: 8] = (state_q == ST_LOAD) ? load_data[OFS +: 8] :
                                 (hit && step_up)     ? inc_v :
                                 (hit && step_dn)     ? dec_v : cur;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         sel_q      <= '0;
         editing_q  <= 1'b0;
         commit_q   <= 1'b0;
         field_q    <= FIELD_MIN;
         btn_prev_q <= '0;
         armed_q    <= 1'b0;
      end else begin
         armed_q    <= 1'b1;
         btn_prev_q <= btn_now;
         field_q    <= field_d;
         commit_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (btn_edge[4]) begin
                  state_q   <= ST_LOAD;
                  editing_q <= 1'b1;
               end
            end
            ST_LOAD: begin
               state_q <= ST_EDIT;
               sel_q   <= '0;
            end
            ST_EDIT: begin
               if (act_p) begin
                  state_q   <= ST_COMMIT;
                  editing_q <= 1'b0;
                  commit_q  <= 1'b1;
               end else if (act_r) begin
                  if (sel_q == SEL_W'(N_FIELDS - 1)) sel_q <= '0;
                  else                               sel_q <= sel_q + 1'b1;
               end else if (act_l) begin
                  if (sel_q == '0) sel_q <= SEL_W'(N_FIELDS - 1);
                  else             sel_q <= sel_q - 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign field_data = field_q;
   assign sel        = sel_q;
   assign editing    = editing_q;
   assign commit     = commit_q;
   assign state      = state_q;

endmodule
